port_kbd: RTL and testbench

- I/O-port responder on the core88 port bus; the device end of the CPU's port_clk/port/port_o/port_w/port_i interface.
- Buffers keyboard scancode bytes from an external front end in a FIFO.
- Exposes a data port (read pops the FIFO) and a status/command port.
- Drives a level interrupt request toward the interrupt controller.

---
 rtl/port_kbd.sv | 141 ++++++++++++++
 tb/tb_port_kbd.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/port_kbd.sv
// port_kbd -- keyboard scancode port on the core88 port bus.
//
// Scancode bytes from the keyboard front end are queued in a small FIFO.
// The CPU reaches the device through two I/O ports:
//   PORT_DATA : read pops the oldest byte (8'h00 when the FIFO is empty);
//               writes are ignored.
//   PORT_STAT : read  -> {4'b0, full, ien, overflow, not_empty}
//               write -> ien = d[2]; d[1] clears overflow; d[7] flushes the FIFO.
// Reads of any other port return 8'hFF.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   port_clk          CPU access strobe (level); one access per rising edge
//   port, port_o      CPU port address / CPU write data
//   port_w            1 = write, 0 = read (qualified by port_clk)
//   port_i            registered read data, held until the next read
//   kb_data/kb_strobe scancode byte and its one-cycle push strobe
//   irq               interrupt request
//
// Build option: PORT_KBD_IRQ_EDGE_EN -- when defined, irq is a one-cycle
// pulse per accepted push while ien is set; otherwise irq is a level that
// follows ien & not_empty.
module port_kbd #(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [15:0] PORT_DATA  = 16'h0060,
    parameter logic [15:0] PORT_STAT  = 16'h0064
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        port_clk,
    input  logic [15:0] port,
    input  logic [7:0]  port_o,
    input  logic        port_w,
    output logic [7:0]  port_i,
    input  logic [7:0]  kb_data,
    input  logic        kb_strobe,
    output logic        irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, ien_q, ien_d;
    logic                  pclk_q;
    logic [7:0]            port_i_q, port_i_d;
    logic                  irq_q, irq_d;

    logic acc, rd, wr, is_data, is_stat, empty, full;
    logic pop, push, drop, flush;

    // Bits of the command byte that carry no meaning.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{port_o[6:3], port_o[0]};

    always_comb begin
        acc     = port_clk & ~pclk_q;
        rd      = acc & ~port_w;
        wr      = acc & port_w;
        is_data = (port == PORT_DATA);
        is_stat = (port == PORT_STAT);
        empty   = (cnt_q == '0);
        full    = (cnt_q == FULL_CNT);
        pop     = rd & is_data & ~empty;
        flush   = wr & is_stat & port_o[7];
        // A pop in the same cycle frees a slot, so a push at full still lands.
        // A flush discards a coincident byte without flagging overflow.
        push    = kb_strobe & ~flush & (~full | pop);
        drop    = kb_strobe & ~flush & full & ~pop;
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        ien_d    = ien_q;
        port_i_d = port_i_q;

        if (rd) begin
            if (is_data)      port_i_d = empty ? 8'h00 : mem[head_q];
            else if (is_stat) port_i_d = {4'b0000, full, ien_q, ovf_q, ~empty};
            else              port_i_d = 8'hFF;
        end

        if (wr && is_stat) begin
            ien_d = port_o[2];
            if (port_o[1]) ovf_d = 1'b0;
        end
        // A byte lost in the same cycle as a clear still leaves overflow set.
        if (drop) ovf_d = 1'b1;

        if (pop)  head_d = head_q + 1'b1;
        if (push) tail_d = tail_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end

`ifdef PORT_KBD_IRQ_EDGE_EN
        irq_d = push & ien_q;
`else
        irq_d = ien_q & ~empty;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ien_q    <= 1'b0;
            pclk_q   <= 1'b0;
            port_i_q <= 8'hFF;
            irq_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            ien_q    <= ien_d;
            pclk_q   <= port_clk;
            port_i_q <= port_i_d;
            irq_q    <= irq_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) mem[tail_q] <= kb_data;
    end

    assign port_i = port_i_q;
    assign irq    = irq_q;
endmodule

// File: tb/tb_port_kbd.sv
module tb_port_kbd;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        port_clk;
    logic [15:0] port;
    logic [7:0]  port_o;
    logic        port_w;
    logic [7:0]  port_i;
    logic [7:0]  kb_data;
    logic        kb_strobe;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Reference model: a byte queue plus the two flags.
    logic [7:0] q[$];
    logic       m_ovf, m_ien, m_prev;
    logic [7:0] exp_port;
    logic       exp_irq;

    port_kbd dut (
        .clock(clock), .reset(reset), .port_clk(port_clk), .port(port),
        .port_o(port_o), .port_w(port_w), .port_i(port_i),
        .kb_data(kb_data), .kb_strobe(kb_strobe), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic stb, input logic [7:0] kd, input logic pc,
                        input logic [15:0] pa, input logic [7:0] pd, input logic pw);
        logic acc, flush, pushed, ien0;
        int   sz0;
        @(negedge clock);
        kb_strobe = stb; kb_data = kd; port_clk = pc; port = pa; port_o = pd; port_w = pw;
        acc = pc && !m_prev;
        m_prev = pc;
        sz0 = q.size();
        ien0 = m_ien;
        flush = 1'b0;
        pushed = 1'b0;
        if (acc && !pw) begin
            if (pa == 16'h0060) begin
                if (sz0 > 0) exp_port = q.pop_front();
                else         exp_port = 8'h00;
            end else if (pa == 16'h0064) begin
                exp_port = {4'b0000, (sz0 == DEPTH), m_ien, m_ovf, (sz0 != 0)};
            end else begin
                exp_port = 8'hFF;
            end
        end
        if (acc && pw && pa == 16'h0064) begin
            m_ien = pd[2];
            if (pd[1]) m_ovf = 1'b0;
            if (pd[7]) begin q.delete(); flush = 1'b1; end
        end
        if (stb && !flush) begin
            if (q.size() < DEPTH) begin q.push_back(kd); pushed = 1'b1; end
            else m_ovf = 1'b1;
        end
`ifdef PORT_KBD_IRQ_EDGE_EN
        exp_irq = pushed && ien0;
`else
        exp_irq = ien0 && (sz0 != 0);
`endif
        @(posedge clock);
        #1;
        chk("port_i", port_i, exp_port);
        chk("irq", {7'b0, irq}, {7'b0, exp_irq});
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0);
    endtask

    task automatic push(input logic [7:0] b);
        step(1'b1, b, 1'b0, 16'h0000, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(1'b0, 8'h00, 1'b1, a, d, 1'b1);
        step(1'b0, 8'h00, 1'b0, a, d, 1'b1);
    endtask

    task automatic rdc(input string tag, input logic [15:0] a, input logic [7:0] want);
        step(1'b0, 8'h00, 1'b1, a, 8'h00, 1'b0);
        chk(tag, port_i, want);
        step(1'b0, 8'h00, 1'b0, a, 8'h00, 1'b0);
    endtask

    initial begin
        logic [15:0] pa;
        reset = 1'b1; port_clk = 0; port = 0; port_o = 0; port_w = 0;
        kb_data = 0; kb_strobe = 0;
        m_ovf = 0; m_ien = 0; m_prev = 0; exp_port = 8'hFF; exp_irq = 0;
        #1;
        chk("rst_port_i", port_i, 8'hFF);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Idle reads after reset.
        rdc("stat_rst", 16'h0064, 8'h00);
        rdc("data_empty", 16'h0060, 8'h00);
        rdc("other_port", 16'h0070, 8'hFF);
        chk("irq_idle", {7'b0, irq}, 8'h00);

        // Two bytes in order.
        push(8'h1C); push(8'h9C);
        rdc("pop1", 16'h0060, 8'h1C);
        rdc("pop2", 16'h0060, 8'h9C);
        rdc("stat_drained", 16'h0064, 8'h00);

        // Level irq follows ien & not-empty with one cycle of lag.
        wr(16'h0064, 8'h04);
        push(8'h2A);
        idle();
`ifndef PORT_KBD_IRQ_EDGE_EN
        chk("irq_set", {7'b0, irq}, 8'h01);
`endif
        step(1'b0, 8'h00, 1'b1, 16'h0060, 8'h00, 1'b0);
        chk("pop_irq", port_i, 8'h2A);
        idle();
        chk("irq_clr", {7'b0, irq}, 8'h00);
        wr(16'h0064, 8'h00);

        // Overflow at depth 8.
        for (int i = 1; i <= 9; i++) push(8'(i));
        rdc("stat_ovf", 16'h0064, 8'h0B);
        for (int i = 1; i <= 8; i++) rdc("ovf_pop", 16'h0060, 8'(i));
        wr(16'h0064, 8'h02);
        rdc("stat_ovf_clr", 16'h0064, 8'h00);

        // Holding port_clk high pops exactly one byte.
        push(8'hAA); push(8'hBB); push(8'hCC);
        repeat (5) step(1'b0, 8'h00, 1'b1, 16'h0060, 8'h00, 1'b0);
        chk("hold_pop", port_i, 8'hAA);
        idle();
        rdc("hold_2", 16'h0060, 8'hBB);
        rdc("hold_3", 16'h0060, 8'hCC);
        rdc("hold_empty", 16'h0060, 8'h00);

        // Wrap: 20 bytes through with a lag of three.
        for (int i = 0; i < 20; i++) begin
            push(8'h40 + 8'(i));
            if (i >= 3) rdc("wrap", 16'h0060, 8'h40 + 8'(i - 3));
        end
        for (int i = 17; i < 20; i++) rdc("wrap_tail", 16'h0060, 8'h40 + 8'(i));

        // Full FIFO: simultaneous push and pop must not overflow.
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
        step(1'b1, 8'hEE, 1'b1, 16'h0060, 8'h00, 1'b0);
        chk("full_pop", port_i, 8'hB0);
        idle();
        rdc("full_stat", 16'h0064, 8'h09);
        // Flush wins over a coincident push.
        step(1'b1, 8'h55, 1'b1, 16'h0064, 8'h80, 1'b1);
        idle();
        rdc("flush_stat", 16'h0064, 8'h00);
        rdc("flush_data", 16'h0060, 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: pa = 16'h0060;
                1: pa = 16'h0064;
                2: pa = 16'h0070;
                default: pa = 16'($urandom);
            endcase
            step($urandom_range(0, 9) < 4, 8'($urandom),
                 $urandom_range(0, 1) == 1, pa,
                 8'($urandom) & (($urandom_range(0, 15) == 0) ? 8'hFF : 8'h7F),
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
